// File: rtl/segan_pkg.sv
// Shared constants for the strided conv1d engine: sample format, conv geometry
// and the sliding-window FSM encoding.
package segan_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int FBITS          = 24;
    localparam int DEF_N_REG      = 31;
    localparam int DEF_LANES      = 2;
    localparam int DEF_PAD_FRONT  = 15;
    localparam int DEF_TAIL_BEATS = 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] TAIL   = 2'd2;

    // Window occupancy after one shift, saturating at the window depth.
    function automatic int sat_fill(input int fill, input int lanes, input int depth);
        return (fill + lanes > depth) ? depth : fill + lanes;
    endfunction

endpackage

// File: rtl/sliding_window_buf_if.sv
// Stream-in / window-out bundle of the sliding window buffer.
interface sliding_window_buf_if
    import segan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REG = DEF_N_REG,
    parameter int LANES = DEF_LANES
);

    // Both sides are valid/ready: a transfer happens on the rising clk edge
    // where valid and ready are both high; valid never waits on ready.
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [N_REG*WIDTH-1:0]   out_window;
    logic                     done;

    modport master (
        output start, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_window, done
    );

    modport slave (
        input  start, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_window, done
    );

endinterface

// File: rtl/win_shift_reg.sv
// Window storage: N_REG sample registers that shift by LANES slots per enable,
// oldest sample in slot 0, with a synchronous clear.
module win_shift_reg
    import segan_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REG = DEF_N_REG,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   shift,
    input  logic [LANES*WIDTH-1:0] load,
    output logic [N_REG*WIDTH-1:0] window
);

    logic [WIDTH-1:0] regs [N_REG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REG; i++) regs[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < N_REG; i++) regs[i] <= '0;
        end else if (shift) begin
            for (int i = 0; i < N_REG - LANES; i++) regs[i] <= regs[i+LANES];
            for (int k = 0; k < LANES; k++) regs[N_REG-LANES+k] <= load[WIDTH*k +: WIDTH];
        end
    end

    for (genvar i = 0; i < N_REG; i++) begin : g_flat
        assign window[WIDTH*i +: WIDTH] = regs[i];
    end

endmodule

// File: rtl/sliding_window_buf.sv
// Sliding-window input buffer: front padding, LANES-wide shifting, tail zero
// injection and a backpressured full-window output for the MAC array.
module sliding_window_buf
    import segan_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int N_REG      = DEF_N_REG,
    parameter int LANES      = DEF_LANES,
    parameter int PAD_FRONT  = DEF_PAD_FRONT,
    parameter int TAIL_BEATS = DEF_TAIL_BEATS
) (
    input  logic                         clk,
    input  logic                         rst,
    sliding_window_buf_if.slave          bus,
    output logic [1:0]                   dbg_state,
    output logic [$clog2(N_REG+1)-1:0]   dbg_fill
);

    localparam int FW = $clog2(N_REG + 1);
    localparam int TW = (TAIL_BEATS > 0) ? $clog2(TAIL_BEATS + 1) : 1;

    logic [1:0]             state;
    logic [FW-1:0]          fill;
    logic [FW-1:0]          fill_inc;
    logic [TW-1:0]          tail_cnt;
    logic                   out_valid_q;
    logic                   done_q;
    logic                   advance;
    logic                   accept;
    logic                   tail_shift;
    logic                   shift;
    logic [LANES*WIDTH-1:0] shift_data;

    // The window may move whenever nothing unconsumed would be overwritten.
    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = (state == STREAM) && advance;
    assign accept        = bus.in_ready && bus.in_valid && !bus.start;
    assign tail_shift    = (state == TAIL) && (tail_cnt != '0) && advance && !bus.start;
    assign shift         = accept || tail_shift;
    assign shift_data    = (state == TAIL) ? '0 : bus.in_data;
    assign fill_inc      = FW'(sat_fill(int'(fill), LANES, N_REG));

    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign dbg_state     = state;
    assign dbg_fill      = fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fill        <= '0;
            tail_cnt    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                // A restart abandons whatever window was pending.
                state       <= STREAM;
                fill        <= FW'(PAD_FRONT);
                tail_cnt    <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (shift) begin
                    fill <= fill_inc;
                    if (fill_inc == FW'(N_REG)) out_valid_q <= 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                end

                case (state)
                    STREAM: begin
                        if (accept && bus.in_last) begin
                            state    <= TAIL;
                            tail_cnt <= TW'(TAIL_BEATS);
                        end
                    end
                    TAIL: begin
                        if (tail_shift) begin
                            tail_cnt <= tail_cnt - TW'(1);
                        end else if ((tail_cnt == '0) && advance) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    win_shift_reg #(
        .WIDTH (WIDTH),
        .N_REG (N_REG),
        .LANES (LANES)
    ) u_win (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.start),
        .shift  (shift),
        .load   (shift_data),
        .window (bus.out_window)
    );

endmodule

// File: tb/tb_sliding_window_buf.sv
// Bench for sliding_window_buf: default geometry plus a LANES=1, N_REG=5 instance,
// checked against windows cut from the padded sample sequence.
module tb_sliding_window_buf;
  import segan_pkg::*;

  localparam int W  = 32;
  localparam int N  = 31;
  localparam int L  = 2;
  localparam int P  = 15;
  localparam int T  = 8;
  localparam int N2 = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sliding_window_buf_if #(.WIDTH(W), .N_REG(N), .LANES(L)) bus ();
  sliding_window_buf_if #(.WIDTH(W), .N_REG(N2), .LANES(1)) bus2 ();

  logic [1:0] st, st2;
  logic [4:0] fill;
  logic [2:0] fill2;

  sliding_window_buf #(.WIDTH(W), .N_REG(N), .LANES(L), .PAD_FRONT(P), .TAIL_BEATS(T)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(st), .dbg_fill(fill)
  );

  sliding_window_buf #(.WIDTH(W), .N_REG(N2), .LANES(1), .PAD_FRONT(0), .TAIL_BEATS(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state(st2), .dbg_fill(fill2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Padded sample sequence: window j is s_q[j*L +: N].
  logic [W-1:0]   s_q[$];
  logic [N*W-1:0] exp_q[$];
  logic [N2*W-1:0] exp2_q[$];

  function automatic logic [N*W-1:0] win_at(input int j);
    logic [N*W-1:0] r = '0;
    for (int i = 0; i < N; i++) r[W*i +: W] = s_q[j*L+i];
    return r;
  endfunction

  function automatic int diff_slot(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    for (int i = 0; i < N; i++) if (a[W*i +: W] !== b[W*i +: W]) return i;
    return -1;
  endfunction

  task automatic init_seq();
    s_q.delete();
    repeat (P) s_q.push_back('0);
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int j = 0; j*L + N <= s_q.size(); j++) exp_q.push_back(win_at(j));
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0; bus.out_ready = 0;
    bus2.start = 0; bus2.in_valid = 0; bus2.in_data = '0; bus2.in_last = 0; bus2.out_ready = 0;
  endtask

  task automatic drive_beat(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = {hi, lo};
    bus.in_last  = last;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_checks++; if (bus.out_window !== '0) begin n_fail++; $display("FAIL reset_window slot %0d nonzero", diff_slot(bus.out_window, '0)); end
    n_checks++; if (st !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", st, IDLE); end
    n_checks++; if (fill !== 5'd0) begin n_fail++; $display("FAIL reset_fill got %0d exp 0", fill); end
    n_checks++; if (bus2.out_window !== '0) begin n_fail++; $display("FAIL reset_window2 got %h exp 0", bus2.out_window); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (st !== IDLE || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_hold state %0d in_ready %b exp %0d/0", st, bus.in_ready, IDLE); end
  endtask

  task automatic test_first_window();
    init_seq();
    for (int k = 0; k < 8; k++) begin s_q.push_back(W'(2*k+1)); s_q.push_back(W'(2*k+2)); end
    pulse_start();
    n_checks++; if (st !== STREAM) begin n_fail++; $display("FAIL start_state got %0d exp %0d", st, STREAM); end
    n_checks++; if (fill !== 5'(P)) begin n_fail++; $display("FAIL start_fill got %0d exp %0d", fill, P); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive_beat(W'(2*k+1), W'(2*k+2), 1'b0);
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ramp_in_ready beat %0d got %b exp 1", k, bus.in_ready); end
      @(negedge clk);
      n_checks++; if (bus.out_valid !== (k == 7)) begin n_fail++; $display("FAIL ramp_out_valid beat %0d got %b exp %b", k, bus.out_valid, k == 7); end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_window !== win_at(0)) begin
      n_fail++;
      $display("FAIL first_window slot %0d got %h exp %h", diff_slot(bus.out_window, win_at(0)),
               bus.out_window[W*diff_slot(bus.out_window, win_at(0)) +: W], s_q[diff_slot(bus.out_window, win_at(0))]);
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] saved;
    s_q.push_back(W'(17)); s_q.push_back(W'(18));
    bus.out_ready = 1'b0;
    drive_beat(W'(17), W'(18), 1'b0);
    saved = bus.out_window;
    repeat (3) begin
      #1;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b exp 0", bus.in_ready); end
      @(negedge clk);
      n_checks++; if (bus.out_window !== saved || bus.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_window slot %0d changed, out_valid %b exp 1", diff_slot(bus.out_window, saved), bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_window !== win_at(1)) begin n_fail++; $display("FAIL release_window mismatch at slot %0d", diff_slot(bus.out_window, win_at(1))); end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL release_out_valid got %b exp 1", bus.out_valid); end
  endtask

  task automatic test_full_sequence();
    logic [W-1:0] data[40];
    logic [N*W-1:0] exp;
    int beat = 0, got = 0, done_cnt = 0, hs_cyc = -1, done_cyc = -2, cyc = 0, after = 0;
    init_seq();
    for (int i = 0; i < 40; i++) begin data[i] = $urandom; s_q.push_back(data[i]); end
    repeat (2*T) s_q.push_back('0);
    build_exp();
    pulse_start();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL restart_drop got %b exp 0", bus.out_valid); end
    while (cyc < 2000 && !(done_cnt > 0 && after >= 4)) begin
      cyc++;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = (beat < 20) && ($urandom_range(0, 3) != 0);
      if (beat < 20) bus.in_data = {data[2*beat+1], data[2*beat]};
      else bus.in_data = '0;
      bus.in_last = (beat == 19);
      #1;
      if (bus.in_valid && bus.in_ready) beat++;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL seq_extra_window at cycle %0d got window exp none", cyc);
        end else begin
          exp = exp_q.pop_front();
          if (bus.out_window !== exp) begin n_fail++; $display("FAIL seq_window %0d slot %0d mismatch", got, diff_slot(bus.out_window, exp)); end
        end
        got++;
        hs_cyc = cyc;
      end
      @(negedge clk);
      if (bus.done) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0) after++;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    n_checks++; if (done_cnt == 0) begin n_fail++; $display("FAIL seq_timeout done got 0 pulses exp 1 within 2000 cycles"); end
    n_checks++; if (got != 21) begin n_fail++; $display("FAIL seq_window_count got %0d exp 21", got); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL seq_done_count got %0d exp 1", done_cnt); end
    n_checks++; if (done_cyc != hs_cyc) begin n_fail++; $display("FAIL seq_done_timing done after cycle %0d exp after %0d", done_cyc, hs_cyc); end
    n_checks++; if (st !== IDLE) begin n_fail++; $display("FAIL seq_end_state got %0d exp %0d", st, IDLE); end
    n_checks++; if (beat != 20) begin n_fail++; $display("FAIL seq_beats got %0d exp 20", beat); end
  endtask

  task automatic test_start_in_tail();
    logic [W-1:0] d[6];
    init_seq();
    for (int i = 0; i < 6; i++) begin d[i] = $urandom; s_q.push_back(d[i]); end
    repeat (2*T) s_q.push_back('0);
    pulse_start();
    bus.out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive_beat(d[2*b], d[2*b+1], b == 2);
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL tail_in_ready beat %0d got %b exp 1", b, bus.in_ready); end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if (st !== TAIL || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL tail_stall state %0d out_valid %b exp %0d/1", st, bus.out_valid, TAIL); end
    n_checks++; if (bus.out_window !== win_at(0)) begin n_fail++; $display("FAIL tail_window slot %0d mismatch", diff_slot(bus.out_window, win_at(0))); end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL tail_restart_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.out_window !== '0) begin n_fail++; $display("FAIL tail_restart_window slot %0d nonzero", diff_slot(bus.out_window, '0)); end
    n_checks++; if (fill !== 5'(P) || st !== STREAM) begin n_fail++; $display("FAIL tail_restart_fill fill %0d state %0d exp %0d/%0d", fill, st, P, STREAM); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL tail_restart_done got %b exp 0", bus.done); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL tail_no_done cycle %0d got %b exp 0", c, bus.done); end
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin drive_beat(W'(100+k), W'(200+k), 1'b0); @(negedge clk); end
    drive_beat(W'(7), W'(8), 1'b0);
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b exp 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got %b exp 0", bus.in_ready); end
    n_checks++; if (bus.out_window !== '0) begin n_fail++; $display("FAIL arst_window slot %0d nonzero", diff_slot(bus.out_window, '0)); end
    n_checks++; if (st !== IDLE || fill !== 5'd0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL arst_state state %0d fill %0d done %b exp 0/0/0", st, fill, bus.done); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    init_seq();
    for (int k = 0; k < 8; k++) begin s_q.push_back(W'(2*k+1)); s_q.push_back(W'(2*k+2)); end
    pulse_start();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin drive_beat(W'(2*k+1), W'(2*k+2), 1'b0); @(negedge clk); end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_resume_valid got %b exp 1", bus.out_valid); end
    n_checks++; if (bus.out_window !== win_at(0)) begin n_fail++; $display("FAIL arst_resume_window slot %0d mismatch", diff_slot(bus.out_window, win_at(0))); end
  endtask

  task automatic test_sweep();
    logic [N2*W-1:0] r;
    int beat = 0, got = 0, done_cnt = 0, hs_cyc = -1, done_cyc = -2, cyc = 0, after = 0;
    exp2_q.delete();
    for (int j = 0; j < 3; j++) begin
      r = '0;
      for (int i = 0; i < N2; i++) r[W*i +: W] = W'(j + i + 1);
      exp2_q.push_back(r);
    end
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    n_checks++; if (st2 !== STREAM || fill2 !== 3'd0) begin n_fail++; $display("FAIL sweep_start state %0d fill %0d exp %0d/0", st2, fill2, STREAM); end
    while (cyc < 200 && !(done_cnt > 0 && after >= 3)) begin
      cyc++;
      bus2.out_ready = ($urandom_range(0, 2) != 0);
      bus2.in_valid  = (beat < 7);
      bus2.in_data   = W'(beat + 1);
      bus2.in_last   = (beat == 6);
      #1;
      if (bus2.in_valid && bus2.in_ready) beat++;
      if (bus2.out_valid && bus2.out_ready) begin
        n_checks++;
        if (exp2_q.size() == 0) begin
          n_fail++; $display("FAIL sweep_extra_window got %h exp none", bus2.out_window);
        end else begin
          r = exp2_q.pop_front();
          if (bus2.out_window !== r) begin n_fail++; $display("FAIL sweep_window %0d got %h exp %h", got, bus2.out_window, r); end
        end
        got++;
        hs_cyc = cyc;
      end
      @(negedge clk);
      if (bus2.done) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0) after++;
    end
    bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
    n_checks++; if (got != 3) begin n_fail++; $display("FAIL sweep_window_count got %0d exp 3", got); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL sweep_done_count got %0d exp 1", done_cnt); end
    n_checks++; if (done_cyc != hs_cyc) begin n_fail++; $display("FAIL sweep_done_timing done after cycle %0d exp after %0d", done_cyc, hs_cyc); end
    n_checks++; if (st2 !== IDLE) begin n_fail++; $display("FAIL sweep_end_state got %0d exp %0d", st2, IDLE); end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_backpressure();
    test_full_sequence();
    test_start_in_tail();
    test_async_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
